// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA timing generator with pixel clock-enable divider and a registered sync/blank/pixel stage.
// Define VGA_TESTPAT_EN to build the colour-bar pattern selected by testpat.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int RGB_W    = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic             testpat,
    output logic             pix_ce,
    output logic [10:0]      pixel_x,
    output logic [9:0]       pixel_y,
    output logic             frame_start,
    output logic [RGB_W-1:0] rgb_out,
    output logic             hsync,
    output logic             vsync,
    output logic             de
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0]    div_q, div_d;
    logic             pix_ce_q, pix_ce_d;
    logic [10:0]      x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             frame_q, frame_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic             x_end, y_end, de_n;
    logic [RGB_W-1:0] src;

`ifdef VGA_TESTPAT_EN
    localparam int CW = RGB_W / 3;
    logic [2:0]       bar;
    logic [RGB_W-1:0] bar_rgb;
    // Bar colours follow a binary pattern: R=~bar[1], G=~bar[2], B=~bar[0]
    always_comb begin
        bar = 3'((32'(x_q) * 8) / H_ACTIVE);
        bar_rgb = '0;
        bar_rgb[RGB_W-1 -: CW]        = {CW{~bar[1]}};
        bar_rgb[RGB_W-1-CW -: CW]     = {CW{~bar[2]}};
        bar_rgb[RGB_W-1-2*CW -: CW]   = {CW{~bar[0]}};
    end
    assign src = testpat ? bar_rgb : rgb_in;
`else
    logic unused_testpat;
    assign unused_testpat = testpat;
    assign src = rgb_in;
`endif

    always_comb begin
        div_d    = div_q == DIV_LAST ? '0 : div_q + 1'b1;
        pix_ce_d = div_q == DIV_LAST;
        x_end    = x_q == H_LAST;
        y_end    = y_q == V_LAST;
        x_d      = pix_ce_q ? (x_end ? '0 : x_q + 11'd1) : x_q;
        y_d      = pix_ce_q && x_end ? (y_end ? '0 : y_q + 10'd1) : y_q;
        frame_d  = pix_ce_q && x_end && y_end;
        de_n     = x_q < H_ACT && y_q < V_ACT;
        de_d     = pix_ce_q ? de_n : de_q;
        hs_d     = pix_ce_q ? (x_q >= H_SS && x_q < H_SE ? H_POL : ~H_POL) : hs_q;
        vs_d     = pix_ce_q ? (y_q >= V_SS && y_q < V_SE ? V_POL : ~V_POL) : vs_q;
        rgb_d    = pix_ce_q ? (de_n ? src : '0) : rgb_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            pix_ce_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            frame_q  <= 1'b0;
            rgb_q    <= '0;
            hs_q     <= ~H_POL;
            vs_q     <= ~V_POL;
            de_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_ce_q <= pix_ce_d;
            x_q      <= x_d;
            y_q      <= y_d;
            frame_q  <= frame_d;
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign frame_start = frame_q;
    assign rgb_out     = rgb_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized bench comparing vga_timing_gen against a clock-count arithmetic model.
module tb_vga_timing_gen;
    localparam int CD = 2, HA = 8, HF = 2, HS = 2, HB = 2, VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
`ifdef VGA_TESTPAT_EN
    localparam bit TP_EN = 1'b1;
`else
    localparam bit TP_EN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0, testpat = 1'b0;
    logic [11:0] rgb_in = '0;
    logic pix_ce, frame_start, hsync, vsync, de;
    logic [10:0] pixel_x;
    logic [9:0] pixel_y;
    logic [11:0] rgb_out;
    logic pce1, fs1, hs1, vs1, de1;
    logic [10:0] x1;
    logic [9:0] y1;
    logic [11:0] rgb1;

    int checks = 0, failures = 0;
    int n = 0;
    logic [11:0] samp = '0;
    bit fix_en = 1'b0, rand_tp = 1'b0;
    logic [11:0] fix_val = '0;

    always #5 clk = ~clk;

    vga_timing_gen #(.CLK_DIV(CD), .RGB_W(12), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(1'b0), .V_POL(1'b0)) dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .testpat(testpat), .pix_ce(pix_ce),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start), .rgb_out(rgb_out),
        .hsync(hsync), .vsync(vsync), .de(de));

    vga_timing_gen #(.CLK_DIV(1), .RGB_W(12), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(1'b0), .V_POL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .testpat(testpat), .pix_ce(pce1),
        .pixel_x(x1), .pixel_y(y1), .frame_start(fs1), .rgb_out(rgb1),
        .hsync(hs1), .vsync(vs1), .de(de1));

    // Model: n = clk edges since reset release; pixel index advanced = floor((n-1)/CD)
    function automatic int pix(int k); return k == 0 ? 0 : (k - 1) / CD; endfunction
    function automatic bit e_pce(int k); return k >= CD && k % CD == 0; endfunction
    function automatic bit adv(int k); return k >= 1 && pix(k) != pix(k - 1); endfunction
    function automatic int e_x(int k); return pix(k) % HT; endfunction
    function automatic int e_y(int k); return (pix(k) / HT) % VT; endfunction
    function automatic int px(int k); return (pix(k) - 1) % HT; endfunction
    function automatic int py(int k); return ((pix(k) - 1) / HT) % VT; endfunction
    function automatic bit e_de(int k); return pix(k) > 0 && px(k) < HA && py(k) < VA; endfunction
    function automatic bit e_hs(int k);
        return !(pix(k) > 0 && px(k) >= HA + HF && px(k) < HA + HF + HS);
    endfunction
    function automatic bit e_vs(int k);
        return !(pix(k) > 0 && py(k) >= VA + VF && py(k) < VA + VF + VS);
    endfunction
    function automatic bit e_fs(int k); return adv(k) && pix(k) % (HT * VT) == 0; endfunction
    function automatic logic [11:0] bar(int xx);
        logic [11:0] t [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        return xx < HA ? t[xx * 8 / HA] : 12'h000;
    endfunction
    function automatic logic [11:0] e_rgb(int k); return e_de(k) ? samp : 12'h000; endfunction

    task automatic tick();
        rgb_in = fix_en ? fix_val : 12'($urandom);
        if (rand_tp) testpat = 1'($urandom);
        @(posedge clk);
        n++;
        if (adv(n)) samp = (TP_EN && testpat) ? bar(px(n)) : rgb_in;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pix_ce, frame_start, de, hsync, vsync, pce1} !== 6'b000110 || pixel_x !== 11'd0 ||
            pixel_y !== 10'd0 || rgb_out !== 12'h000) begin
            failures++;
            $display("FAIL reset_state: got ce=%b fs=%b de=%b hs=%b vs=%b ce1=%b x=%0d y=%0d rgb=%h, want 0 0 0 1 1 0 0 0 000",
                     pix_ce, frame_start, de, hsync, vsync, pce1, pixel_x, pixel_y, rgb_out);
        end
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pix_ce !== e_pce(n)) begin
                failures++;
                $display("FAIL first_pix_ce clk %0d: got %b want %b", n, pix_ce, e_pce(n));
            end
        end
    endtask

    task automatic test_divider();
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (pix_ce !== e_pce(n) || pce1 !== 1'b1) begin
                failures++;
                $display("FAIL divider clk %0d: got ce=%b ce1=%b want ce=%b ce1=1", n, pix_ce, pce1, e_pce(n));
            end
        end
    endtask

    task automatic test_line();
        for (int i = 0; i < 2 * HT * CD * 2; i++) begin
            tick();
            checks++;
            if (pixel_x !== 11'(e_x(n)) || pixel_y !== 10'(e_y(n)) || hsync !== e_hs(n) || de !== e_de(n)) begin
                failures++;
                $display("FAIL line clk %0d: got x=%0d y=%0d hs=%b de=%b want x=%0d y=%0d hs=%b de=%b",
                         n, pixel_x, pixel_y, hsync, de, e_x(n), e_y(n), e_hs(n), e_de(n));
            end
        end
    endtask

    task automatic test_frame();
        int last = -1, seen = 0;
        for (int i = 0; i < 2 * HT * VT * CD + 4; i++) begin
            tick();
            checks++;
            if (vsync !== e_vs(n) || frame_start !== e_fs(n) || pixel_y !== 10'(e_y(n))) begin
                failures++;
                $display("FAIL frame clk %0d: got vs=%b fs=%b y=%0d want vs=%b fs=%b y=%0d",
                         n, vsync, frame_start, pixel_y, e_vs(n), e_fs(n), e_y(n));
            end
            if (frame_start === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (n - last != HT * VT * CD) begin
                        failures++;
                        $display("FAIL frame_period: got %0d want %0d", n - last, HT * VT * CD);
                    end
                end
                last = n;
                seen++;
            end
        end
        checks++;
        if (seen < 2) begin
            failures++;
            $display("FAIL frame_start_count: got %0d want >=2", seen);
        end
    endtask

    task automatic test_data();
        fix_en = 1'b1;
        fix_val = 12'hABC;
        for (int i = 0; i < HT * VT * CD; i++) begin
            tick();
            checks++;
            if (rgb_out !== e_rgb(n) || de !== e_de(n)) begin
                failures++;
                $display("FAIL data_abc clk %0d: got rgb=%h de=%b want rgb=%h de=%b", n, rgb_out, de, e_rgb(n), e_de(n));
            end
        end
        fix_en = 1'b0;
        rand_tp = 1'b1;
        for (int i = 0; i < HT * VT * CD; i++) begin
            tick();
            checks++;
            if (rgb_out !== e_rgb(n)) begin
                failures++;
                $display("FAIL data_rand clk %0d: got %h want %h", n, rgb_out, e_rgb(n));
            end
        end
        rand_tp = 1'b0;
        testpat = 1'b0;
    endtask

    task automatic test_testpat();
        testpat = 1'b1;
        for (int i = 0; i < HT * CD * 2; i++) begin
            tick();
            if (e_de(n) && (px(n) == 0 || px(n) == 7)) begin
                checks++;
                if (rgb_out !== (TP_EN ? (px(n) == 0 ? 12'hFFF : 12'h000) : samp)) begin
                    failures++;
                    $display("FAIL testpat x=%0d: got %h", px(n), rgb_out);
                end
            end
        end
        testpat = 1'b0;
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < HT * VT * CD * 2 && !(e_x(n) == 5 && e_y(n) == 2); i++) tick();
        checks++;
        if (pixel_x !== 11'd5 || pixel_y !== 10'd2) begin
            failures++;
            $display("FAIL pre_reset_pos: got (%0d,%0d) want (5,2)", pixel_x, pixel_y);
        end
        #2;
        reset = 1'b0;
        n = 0;
        #1;
        checks++;
        if ({pix_ce, frame_start, de, hsync, vsync} !== 5'b00011 || pixel_x !== 11'd0 ||
            pixel_y !== 10'd0 || rgb_out !== 12'h000) begin
            failures++;
            $display("FAIL midframe_reset: got ce=%b fs=%b de=%b hs=%b vs=%b x=%0d y=%0d rgb=%h",
                     pix_ce, frame_start, de, hsync, vsync, pixel_x, pixel_y, rgb_out);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (pixel_x !== 11'(e_x(n)) || pixel_y !== 10'(e_y(n)) || pix_ce !== e_pce(n) || frame_start !== 1'b0) begin
                failures++;
                $display("FAIL restart clk %0d: got x=%0d y=%0d ce=%b fs=%b want x=%0d y=%0d ce=%b fs=0",
                         n, pixel_x, pixel_y, pix_ce, frame_start, e_x(n), e_y(n), e_pce(n));
            end
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_line();
        test_frame();
        test_data();
        test_testpat();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
